crop_frame_ctrl: RTL and testbench

Per-frame sequencer for the crop/normalize stage. It latches host-written crop coordinates into a shadow register and commits them only at frame boundaries. It issues the `ap_start`/`ap_ready` handshake, tracks raster position from the pixel-stream handshake to drive `cnt_col`/`cnt_row`, and waits for `ap_done` before arming the next frame. It sits between the host register bank / frame grabber control and the crop+norm datapath, with timeout and configuration-error reporting.

---
 rtl/crop_frame_ctrl_if.sv | 25 ++
 rtl/crop_frame_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_crop_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crop_frame_ctrl_if.sv
// Start/done handshake with the crop+norm datapath plus the pixel-stream handshake it consumes.
// The controller (master) only observes the pixel stream; it never drives it.
interface crop_frame_ctrl_if;
    logic cn_ap_start;
    logic cn_ap_ready;
    logic cn_ap_done;
    logic pix_tvalid;
    logic pix_tready;

    modport master (
        output cn_ap_start,
        input  cn_ap_ready,
        input  cn_ap_done,
        input  pix_tvalid,
        input  pix_tready
    );

    modport slave (
        input  cn_ap_start,
        output cn_ap_ready,
        output cn_ap_done,
        output pix_tvalid,
        output pix_tready
    );
endinterface

// File: rtl/crop_frame_ctrl.sv
// Per-frame sequencer for the crop/normalize stage: shadowed crop coordinates committed at frame
// boundaries, ap_start/ap_done handshake, raster tracking, progress timeout and sticky errors.
module crop_frame_ctrl #(
    parameter int unsigned IN_ROWS        = 20,
    parameter int unsigned IN_COLS        = 20,
    parameter int unsigned OUT_ROWS       = 10,
    parameter int unsigned OUT_COLS       = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       seq_ap_idle,
    input  logic                       cfg_valid,
    input  logic [$clog2(IN_COLS)-1:0] cfg_x0,
    input  logic [$clog2(IN_ROWS)-1:0] cfg_y0,
    crop_frame_ctrl_if.master          cn,
    output logic [$clog2(IN_COLS)-1:0] crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic [$clog2(IN_COLS)-1:0] cnt_col,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row,
    output logic                       busy,
    output logic [15:0]                frame_count,
    output logic                       err_timeout,
    output logic                       err_cfg,
    input  logic                       err_clr
);

    localparam int unsigned XW = $clog2(IN_COLS);
    localparam int unsigned YW = $clog2(IN_ROWS);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [XW-1:0] XMax    = XW'(IN_COLS - OUT_COLS);
    localparam logic [YW-1:0] YMax    = YW'(IN_ROWS - OUT_ROWS);
    localparam logic [XW-1:0] ColLast = XW'(IN_COLS - 1);
    localparam logic [YW-1:0] RowLast = YW'(IN_ROWS - 1);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StStream,
        StWaitDone
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] shadow_x_q, shadow_x_d;
    logic [YW-1:0] shadow_y_q, shadow_y_d;
    logic [XW-1:0] crop_x_q, crop_x_d;
    logic [YW-1:0] crop_y_q, crop_y_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          err_tmo_q, err_tmo_d;
    logic          err_cfg_q, err_cfg_d;
    logic          start_q;
    logic          busy_q;
    logic          pix_hs;
    logic          can_start;

    assign pix_hs    = cn.pix_tvalid && cn.pix_tready;
    assign can_start = enable && seq_ap_idle;

    always_comb begin
        state_d     = state_q;
        shadow_x_d  = cfg_valid ? cfg_x0 : shadow_x_q;
        shadow_y_d  = cfg_valid ? cfg_y0 : shadow_y_q;
        crop_x_d    = crop_x_q;
        crop_y_d    = crop_y_q;
        col_d       = col_q;
        row_d       = row_q;
        // Timeout counter is zero outside STREAM/WAIT_DONE, so every state entry starts it afresh.
        tmo_d       = '0;
        frame_cnt_d = frame_cnt_q;
        err_tmo_d   = err_clr ? 1'b0 : err_tmo_q;
        err_cfg_d   = err_clr ? 1'b0 : err_cfg_q;

        case (state_q)
            StIdle: begin
                if (can_start) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
                // Commit reads the registered shadow, so a same-cycle cfg write lands next frame.
                if (shadow_x_q > XMax) begin
                    crop_x_d  = XMax;
                    err_cfg_d = 1'b1;
                end else begin
                    crop_x_d = shadow_x_q;
                end
                if (shadow_y_q > YMax) begin
                    crop_y_d  = YMax;
                    err_cfg_d = 1'b1;
                end else begin
                    crop_y_d = shadow_y_q;
                end
                col_d   = '0;
                row_d   = '0;
                state_d = StStart;
            end

            StStart: begin
                if (cn.cn_ap_ready) begin
                    state_d = StStream;
                end
            end

            StStream: begin
                if (pix_hs) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            row_d   = '0;
                            state_d = StWaitDone;
                        end else begin
                            row_d = row_q + YW'(1);
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end else if (tmo_q == TmoLast) begin
                    err_tmo_d = 1'b1;
                    col_d     = '0;
                    row_d     = '0;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            StWaitDone: begin
                if (cn.cn_ap_done) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = can_start ? StLoad : StIdle;
                end else if (tmo_q == TmoLast) begin
                    err_tmo_d = 1'b1;
                    col_d     = '0;
                    row_d     = '0;
                    state_d   = StIdle;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            crop_x_q    <= '0;
            crop_y_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            tmo_q       <= '0;
            frame_cnt_q <= '0;
            err_tmo_q   <= 1'b0;
            err_cfg_q   <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            crop_x_q    <= crop_x_d;
            crop_y_q    <= crop_y_d;
            col_q       <= col_d;
            row_q       <= row_d;
            tmo_q       <= tmo_d;
            frame_cnt_q <= frame_cnt_d;
            err_tmo_q   <= err_tmo_d;
            err_cfg_q   <= err_cfg_d;
            start_q     <= (state_d == StStart);
            // Lags the state by one cycle: busy falls the cycle after IDLE is entered.
            busy_q      <= (state_q != StIdle);
        end
    end

    assign cn.cn_ap_start = start_q;
    assign crop_x0        = crop_x_q;
    assign crop_y0        = crop_y_q;
    assign cnt_col        = col_q;
    assign cnt_row        = row_q;
    assign busy           = busy_q;
    assign frame_count    = frame_cnt_q;
    assign err_timeout    = err_tmo_q;
    assign err_cfg        = err_cfg_q;

endmodule

// File: tb/tb_crop_frame_ctrl.sv
// Directed bench for crop_frame_ctrl: frame sequencing, shadow commit/clamp, raster counters,
// timeout and enable drop, with hand-computed expectations.
module tb_crop_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       seq_ap_idle;
    logic       cfg_valid;
    logic [4:0] cfg_x0;
    logic [4:0] cfg_y0;
    logic [4:0] crop_x0;
    logic [4:0] crop_y0;
    logic [4:0] cnt_col;
    logic [4:0] cnt_row;
    logic       busy;
    logic [15:0] frame_count;
    logic       err_timeout;
    logic       err_cfg;
    logic       err_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_col  = 0;
    int exp_row  = 0;

    crop_frame_ctrl_if cn ();

    crop_frame_ctrl #(
        .IN_ROWS        (20),
        .IN_COLS        (20),
        .OUT_ROWS       (10),
        .OUT_COLS       (10),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .seq_ap_idle (seq_ap_idle),
        .cfg_valid   (cfg_valid),
        .cfg_x0      (cfg_x0),
        .cfg_y0      (cfg_y0),
        .cn          (cn.master),
        .crop_x0     (crop_x0),
        .crop_y0     (crop_y0),
        .cnt_col     (cnt_col),
        .cnt_row     (cnt_row),
        .busy        (busy),
        .frame_count (frame_count),
        .err_timeout (err_timeout),
        .err_cfg     (err_cfg),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [4:0] x, input logic [4:0] y);
        cfg_valid = 1'b1;
        cfg_x0    = x;
        cfg_y0    = y;
        step();
        cfg_valid = 1'b0;
    endtask

    // Called in the LOAD cycle; walks through START into STREAM with cn_ap_ready held high.
    task automatic begin_frame(input int ex, input int ey);
        check_eq("start_low_in_load", 32'(cn.cn_ap_start), 0);
        step();
        cfg_valid = 1'b0;
        check_eq("start_high", 32'(cn.cn_ap_start), 1);
        check_eq("crop_x0", 32'(crop_x0), ex);
        check_eq("crop_y0", 32'(crop_y0), ey);
        step();
        check_eq("start_drop", 32'(cn.cn_ap_start), 0);
    endtask

    task automatic stream_pixels(input int n, input bit rnd);
        int  hs  = 0;
        int  gap = 0;
        logic v, r;
        while (hs < n) begin
            if (rnd && gap < 40) begin
                v = 1'($urandom_range(0, 1));
                r = 1'($urandom_range(0, 1));
            end else begin
                v = 1'b1;
                r = 1'b1;
            end
            cn.pix_tvalid = v;
            cn.pix_tready = r;
            if (v && r) begin
                check_eq("pix_pos", 32'(cnt_row) * 100 + 32'(cnt_col),
                         32'(exp_row * 100 + exp_col));
                if (exp_col == 19) begin
                    exp_col = 0;
                    exp_row = (exp_row == 19) ? 0 : exp_row + 1;
                end else begin
                    exp_col++;
                end
                hs++;
                gap = 0;
            end else begin
                gap++;
            end
            step();
        end
        cn.pix_tvalid = 1'b0;
        cn.pix_tready = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        seq_ap_idle    = 1'b0;
        cfg_valid      = 1'b0;
        cfg_x0         = '0;
        cfg_y0         = '0;
        err_clr        = 1'b0;
        cn.cn_ap_ready = 1'b0;
        cn.cn_ap_done  = 1'b0;
        cn.pix_tvalid  = 1'b0;
        cn.pix_tready  = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        check_eq("rst_start", 32'(cn.cn_ap_start), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_frame_count", 32'(frame_count), 0);
        check_eq("rst_crop", 32'({crop_x0, crop_y0}), 0);
        check_eq("rst_cnt", 32'({cnt_col, cnt_row}), 0);
        check_eq("rst_errs", 32'({err_timeout, err_cfg}), 0);

        // Frame 1: shadow (3,4), continuous stream.
        write_cfg(5'd3, 5'd4);
        enable         = 1'b1;
        seq_ap_idle    = 1'b1;
        cn.cn_ap_ready = 1'b1;
        step();
        begin_frame(3, 4);
        check_eq("busy_in_frame", 32'(busy), 1);
        stream_pixels(400, 1'b0);
        check_eq("f1_cnt_wrap", 32'({cnt_col, cnt_row}), 0);
        check_eq("f1_fc_before_done", 32'(frame_count), 0);
        write_cfg(5'd15, 5'd2);
        repeat (4) step();
        cn.cn_ap_done = 1'b1;
        step();
        cn.cn_ap_done = 1'b0;
        check_eq("f1_frame_count", 32'(frame_count), 1);

        // Frame 2: clamped x, then err_clr, random stream gaps.
        begin_frame(10, 2);
        check_eq("f2_err_cfg_set", 32'(err_cfg), 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("f2_err_cfg_clr", 32'(err_cfg), 0);
        write_cfg(5'd1, 5'd1);
        stream_pixels(400, 1'b1);
        check_eq("f2_no_timeout", 32'(err_timeout), 0);
        check_eq("f2_cnt_wrap", 32'({cnt_col, cnt_row}), 0);
        check_eq("f2_busy", 32'(busy), 1);
        repeat (2) step();
        cn.cn_ap_done = 1'b1;
        step();
        cn.cn_ap_done = 1'b0;
        check_eq("f2_frame_count", 32'(frame_count), 2);

        // Frame 3: cfg write during LOAD affects the next frame only.
        cfg_valid = 1'b1;
        cfg_x0    = 5'd7;
        cfg_y0    = 5'd7;
        begin_frame(1, 1);
        check_eq("f3_err_cfg", 32'(err_cfg), 0);
        stream_pixels(400, 1'b0);
        cn.cn_ap_done = 1'b1;
        step();
        cn.cn_ap_done = 1'b0;
        check_eq("f3_frame_count", 32'(frame_count), 3);

        // Frame 4: stall after pixel 123 until timeout.
        begin_frame(7, 7);
        stream_pixels(123, 1'b0);
        enable = 1'b0;
        check_eq("f4_stall_pos", 32'(cnt_row) * 100 + 32'(cnt_col), 603);
        repeat (63) step();
        check_eq("f4_no_err_yet", 32'(err_timeout), 0);
        check_eq("f4_busy_stall", 32'(busy), 1);
        step();
        check_eq("f4_err_timeout", 32'(err_timeout), 1);
        check_eq("f4_cnt_zero", 32'({cnt_col, cnt_row}), 0);
        check_eq("f4_fc_unchanged", 32'(frame_count), 3);
        check_eq("f4_no_start", 32'(cn.cn_ap_start), 0);
        step();
        check_eq("f4_busy_low", 32'(busy), 0);
        exp_col = 0;
        exp_row = 0;

        cn.cn_ap_done = 1'b1;
        step();
        cn.cn_ap_done = 1'b0;
        check_eq("done_ignored_idle", 32'(frame_count), 3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("err_timeout_clr", 32'(err_timeout), 0);

        enable      = 1'b1;
        seq_ap_idle = 1'b0;
        repeat (3) step();
        check_eq("idle_gated_busy", 32'(busy), 0);
        check_eq("idle_gated_start", 32'(cn.cn_ap_start), 0);

        // Frame 5: enable drops mid-frame; frame completes, no restart.
        seq_ap_idle = 1'b1;
        step();
        begin_frame(7, 7);
        stream_pixels(200, 1'b0);
        enable = 1'b0;
        stream_pixels(200, 1'b0);
        check_eq("f5_cnt_wrap", 32'({cnt_col, cnt_row}), 0);
        cn.cn_ap_done = 1'b1;
        step();
        cn.cn_ap_done = 1'b0;
        check_eq("f5_frame_count", 32'(frame_count), 4);
        step();
        check_eq("f5_busy_low", 32'(busy), 0);
        repeat (4) step();
        check_eq("f5_no_restart", 32'(cn.cn_ap_start), 0);
        check_eq("f5_still_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
